// File: rtl/inv_cipher.sv
// inv_cipher: iterative AES inverse cipher (AES-128/192/256), one round per clock.
// Key schedule is expanded one word per clock into a local word array.
// Optional build macro INV_CIPHER_KEY_CACHE_EN: reuse the expanded schedule when
// a new block arrives with the same key, skipping key expansion.

package inv_cipher_pkg;
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, r;
    p = a;
    r = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      if (b[k]) r = r ^ p;
      p = xtime(p);
    end
    return r;
  endfunction

  // a^254 is the multiplicative inverse in GF(2^8); 0 maps to 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] p, r;
    p = a;
    r = 8'h01;
    for (int unsigned k = 1; k < 8; k++) begin
      p = gf_mul(p, p);
      r = gf_mul(r, p);
    end
    return r;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
    return (x << n) | (x >> (8 - n));
  endfunction

  // column bytes a0..a3 are rows 0..3, a0 in the top byte
  function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    {a0, a1, a2, a3} = col;
    return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
            gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
            gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
            gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
  endfunction
endpackage

// Forward AES S-box: field inverse followed by the affine map.
module sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import inv_cipher_pkg::*;
  logic [7:0] b;
  // substitution is pure combinational arithmetic
  always_comb begin
    b = gf_inv(a);
    y = b ^ rotl8(b, 1) ^ rotl8(b, 2) ^ rotl8(b, 3) ^ rotl8(b, 4) ^ 8'h63;
  end
endmodule

// Inverse AES S-box: inverse affine map followed by the field inverse.
module inv_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  import inv_cipher_pkg::*;
  logic [7:0] b;
  // substitution is pure combinational arithmetic
  always_comb begin
    b = rotl8(a, 1) ^ rotl8(a, 3) ^ rotl8(a, 6) ^ 8'h05;
    y = gf_inv(b);
  end
endmodule

module inv_cipher #(
  parameter int Nk = 4,
  parameter int Nr = 10,
  localparam int Nkb = Nk * 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [0:127]   in,
  input  logic [0:Nkb-1] key,
  input  logic           valid_in,
  output logic           ready_in,
  output logic [0:127]   out,
  output logic           valid_out
);
  import inv_cipher_pkg::*;

  localparam int NW  = 4 * (Nr + 1);
  localparam int WIW = $clog2(NW);
  localparam int RW  = $clog2(Nr + 1);

  typedef enum logic [2:0] {IDLE, KEXP, ARK, ROUND, FINAL} state_t;
  state_t state, state_nx;

  logic [NW-1:0][31:0] w;
  logic [Nk-1:0][31:0] key_w;
  logic [0:127]        dreg, sr, sb, ak, mc, rk;
  logic [WIW-1:0]      widx, idx_prev, idx_back, rk_base;
  logic [2:0]          kcnt;
  logic [7:0]          rcon;
  logic [RW-1:0]       rnd, rk_idx;
  logic [31:0]         temp, sub_in, sub_out, w_new;
  logic                xfer, hit, kexp_done;

  assign xfer      = valid_in && ready_in;
  assign kexp_done = (widx == WIW'(NW - 1));

  for (genvar g = 0; g < Nk; g++) begin : g_keyw
    assign key_w[g] = key[32*g +: 32];
  end

`ifdef INV_CIPHER_KEY_CACHE_EN
  logic          cache_valid;
  logic [Nk-1:0] key_eq;
  // w[0..Nk-1] always holds the key that produced the current schedule
  for (genvar g = 0; g < Nk; g++) begin : g_cmp
    assign key_eq[g] = (key_w[g] == w[g]);
  end
  assign hit = cache_valid && (&key_eq);

  // schedule is trusted only after an uninterrupted expansion
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                             cache_valid <= 1'b0;
    else if (state == IDLE && xfer && !hit) cache_valid <= 1'b0;
    else if (state == KEXP && kexp_done) cache_valid <= 1'b1;
  end
`else
  assign hit = 1'b0;
`endif

  // key expansion word: kcnt tracks i mod Nk without a divider
  assign idx_prev = widx - WIW'(1);
  assign idx_back = widx - WIW'(Nk);
  assign temp     = w[idx_prev];
  assign sub_in   = (kcnt == 3'd0) ? {temp[23:0], temp[31:24]} : temp;

  for (genvar g = 0; g < 4; g++) begin : g_ksbox
    sbox u_sbox (.a(sub_in[8*g +: 8]), .y(sub_out[8*g +: 8]));
  end

  // next schedule word
  always_comb begin
    if (kcnt == 3'd0)
      w_new = w[idx_back] ^ sub_out ^ {rcon, 24'h0};
    else if (Nk > 6 && kcnt == 3'd4)
      w_new = w[idx_back] ^ sub_out;
    else
      w_new = w[idx_back] ^ temp;
  end

  // round key selection: ARK uses round Nr, FINAL round 0, ROUND the counter
  always_comb begin
    if (state == ARK)        rk_idx = RW'(Nr);
    else if (state == FINAL) rk_idx = '0;
    else                     rk_idx = rnd;
  end
  assign rk_base = WIW'({rk_idx, 2'b00});

  for (genvar g = 0; g < 4; g++) begin : g_rk
    assign rk[32*g +: 32] = w[rk_base + WIW'(g)];
  end

  // InvShiftRows -> InvSubBytes -> AddRoundKey -> InvMixColumns
  for (genvar c = 0; c < 4; c++) begin : g_col
    for (genvar r = 0; r < 4; r++) begin : g_row
      localparam int SRC = r + 4 * ((c - r + 4) % 4);
      assign sr[8*(r+4*c) +: 8] = dreg[8*SRC +: 8];
      inv_sbox u_isbox (.a(sr[8*(r+4*c) +: 8]), .y(sb[8*(r+4*c) +: 8]));
    end
    assign mc[32*c +: 32] = inv_mix_col(ak[32*c +: 32]);
  end
  assign ak = sb ^ rk;

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // next-state logic; legal Nr is always > 1 so ARK always enters ROUND
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (xfer) state_nx = hit ? ARK : KEXP;
      KEXP:    if (kexp_done) state_nx = ARK;
      ARK:     state_nx = ROUND;
      ROUND:   if (rnd == RW'(1)) state_nx = FINAL;
      FINAL:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // datapath, counters and handshake outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ready_in  <= 1'b0;
      valid_out <= 1'b0;
      out       <= '0;
      dreg      <= '0;
      widx      <= '0;
      kcnt      <= '0;
      rcon      <= '0;
      rnd       <= '0;
    end else begin
      ready_in  <= (state_nx == IDLE);
      valid_out <= 1'b0;
      case (state)
        IDLE: if (xfer) begin
          dreg <= in;
          widx <= WIW'(Nk);
          kcnt <= '0;
          rcon <= 8'h01;
        end
        KEXP: begin
          widx <= widx + WIW'(1);
          kcnt <= (kcnt == 3'(Nk - 1)) ? 3'd0 : kcnt + 3'd1;
          if (kcnt == 3'd0) rcon <= xtime(rcon);
        end
        ARK: begin
          dreg <= dreg ^ rk;
          rnd  <= RW'(Nr - 1);
        end
        ROUND: begin
          dreg <= mc;
          rnd  <= rnd - RW'(1);
        end
        FINAL: begin
          out       <= ak;
          valid_out <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // key schedule storage: key words on transfer, one derived word per KEXP cycle
  always_ff @(posedge clk) begin
    if (state == IDLE && xfer) begin
      for (int unsigned j = 0; j < Nk; j++) w[j] <= key_w[j];
    end else if (state == KEXP) begin
      w[widx] <= w_new;
    end
  end
endmodule

// File: tb/tb_inv_cipher.sv
// Scoreboard bench for inv_cipher: AES-128, AES-192 and AES-256 instances.
module tb_inv_cipher;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic         vin  [3];
  logic         rdy  [3];
  logic         vout [3];
  logic [127:0] din  [3];
  logic [127:0] dout [3];
  logic [255:0] dkey [3];

  inv_cipher #(.Nk(4), .Nr(10)) u_aes128 (
    .clk(clk), .rst(rst), .in(din[0]), .key(dkey[0][255:128]), .valid_in(vin[0]),
    .ready_in(rdy[0]), .out(dout[0]), .valid_out(vout[0]));
  inv_cipher #(.Nk(6), .Nr(12)) u_aes192 (
    .clk(clk), .rst(rst), .in(din[1]), .key(dkey[1][255:64]), .valid_in(vin[1]),
    .ready_in(rdy[1]), .out(dout[1]), .valid_out(vout[1]));
  inv_cipher #(.Nk(8), .Nr(14)) u_aes256 (
    .clk(clk), .rst(rst), .in(din[2]), .key(dkey[2]), .valid_in(vin[2]),
    .ready_in(rdy[2]), .out(dout[2]), .valid_out(vout[2]));

  typedef struct { int unsigned inst; logic [255:0] key; logic [127:0] ct; logic [127:0] pt; } vec_t;
  typedef struct { logic [127:0] pt; int unsigned cyc; } exp_t;

  vec_t        vt [4];
  exp_t        sbq [3][$];
  int unsigned lat_full [3] = '{51, 59, 67};
  int unsigned lat_hit  [3] = '{11, 13, 15};
  logic [255:0] cached_key [3];
  bit          cache_ok [3];
  int unsigned acc_cnt [3] = '{0, 0, 0};
  int unsigned acc_at  [3] = '{32'hffffffff, 32'hffffffff, 32'hffffffff};
  bit          prev_v [3] = '{0, 0, 0};
  int unsigned cyc = 0;
  int          n_vec = 0;
  int          n_bad = 0;

  function automatic void chk(input string name, input int inst, input logic [127:0] act,
                              input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s inst %0d: got %h, required %h", name, inst, act, req);
    end
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // acceptance watcher: push reference plaintext and due cycle for each transfer
  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        sbq[i].delete();
        cache_ok[i] = 1'b0;
      end else if (vin[i] && rdy[i]) begin
        exp_t e;
        bit   hit;
        e.pt = 'x;
        foreach (vt[v])
          if (vt[v].inst == i && vt[v].key == dkey[i] && vt[v].ct == din[i]) e.pt = vt[v].pt;
        hit = 1'b0;
`ifdef INV_CIPHER_KEY_CACHE_EN
        hit = cache_ok[i] && (cached_key[i] == dkey[i]);
`endif
        if (!hit) begin
          cached_key[i] = dkey[i];
          cache_ok[i]   = 1'b1;
        end
        e.cyc = cyc + 1 + (hit ? lat_hit[i] : lat_full[i]);
        sbq[i].push_back(e);
        acc_cnt[i]++;
        acc_at[i] = cyc + 1;
      end
    end
  end

  // monitor: compare outputs against the scoreboard away from the clock edge
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      exp_t e;
      if (!rst && acc_at[i] == cyc) chk("busy_after_accept", i, 128'(rdy[i]), 128'd0);
      if (vout[i]) begin
        chk("pulse_width", i, 128'(prev_v[i]), 128'd0);
        chk("ready_at_done", i, 128'(rdy[i]), 128'd1);
        if (sbq[i].size() == 0) begin
          n_vec++;
          n_bad++;
          $display("FAIL unexpected_valid_out inst %0d: got out %h, required no output", i, dout[i]);
        end else begin
          e = sbq[i].pop_front();
          chk("plaintext", i, dout[i], e.pt);
          chk("latency_cycle", i, 128'(cyc), 128'(e.cyc));
        end
      end else if (sbq[i].size() != 0 && cyc > sbq[i][0].cyc) begin
        e = sbq[i].pop_front();
        n_vec++;
        n_bad++;
        $display("FAIL missing_valid_out inst %0d: got none by cycle %0d, required at cycle %0d",
                 i, cyc, e.cyc);
      end
      prev_v[i] = vout[i];
    end
  end

  task automatic send(input int v);
    int unsigned i, c0;
    int n;
    i = vt[v].inst;
    @(negedge clk);
    din[i]  = vt[v].ct;
    dkey[i] = vt[v].key;
    vin[i]  = 1'b1;
    c0 = acc_cnt[i];
    n = 0;
    while (acc_cnt[i] == c0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    vin[i] = 1'b0;
    if (acc_cnt[i] == c0) begin
      n_vec++;
      n_bad++;
      $display("FAIL accept_timeout inst %0d: got no transfer, required one", i);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((sbq[0].size() + sbq[1].size() + sbq[2].size()) != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    chk("async_rst_out", 0, dout[0], 128'd0);
    chk("async_rst_valid", 0, 128'(vout[0]), 128'd0);
    chk("async_rst_ready", 0, 128'(rdy[0]), 128'd0);
    @(negedge clk);
    chk("rst_ready_held", 0, 128'(rdy[0]), 128'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    int unsigned c0, k;
    int n, tog;
    vt[0] = '{0, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
              128'h69c4e0d86a7b0430d8cdb78070b4c55a, 128'h00112233445566778899aabbccddeeff};
    vt[1] = '{0, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0},
              128'h3925841d02dc09fbdc118597196a0b32, 128'h3243f6a8885a308d313198a2e0370734};
    vt[2] = '{1, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
              128'hdda97ca4864cdfe06eaf70a0ec0d7191, 128'h00112233445566778899aabbccddeeff};
    vt[3] = '{2, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
              128'h8ea2b7ca516745bfeafc49904b496089, 128'h00112233445566778899aabbccddeeff};
    for (int i = 0; i < 3; i++) begin
      vin[i] = 1'b0; din[i] = '0; dkey[i] = '0;
    end

    rst = 1'b1;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk("reset_ready", i, 128'(rdy[i]), 128'd0);
      chk("reset_out", i, dout[i], 128'd0);
      chk("reset_valid", i, 128'(vout[i]), 128'd0);
    end
    rst = 1'b0;
    #1 chk("ready_before_first_edge", 0, 128'(rdy[0]), 128'd0);
    @(negedge clk);
    for (int i = 0; i < 3; i++) chk("ready_after_reset", i, 128'(rdy[i]), 128'd1);

    // directed known-answer vectors, repeated keys exercise the cache path
    send(0); wait_idle();
    send(1); wait_idle();
    send(1); wait_idle();
    send(2); wait_idle();
    send(3); wait_idle();
    send(3); wait_idle();

    // valid_in held high with in/key changing every cycle
    c0 = acc_cnt[0];
    @(negedge clk);
    vin[0] = 1'b1;
    n = 0;
    tog = 0;
    while (acc_cnt[0] < c0 + 3 && n < 400) begin
      din[0]  = vt[tog].ct;
      dkey[0] = vt[tog].key;
      tog = 1 - tog;
      @(negedge clk);
      n++;
    end
    vin[0] = 1'b0;
    if (acc_cnt[0] < c0 + 3) begin
      n_vec++;
      n_bad++;
      $display("FAIL busy_accepts inst 0: got %0d transfers, required 3", acc_cnt[0] - c0);
    end
    wait_idle();

    // reset during key expansion (key differs from cached one)
    send(1); wait_idle();
    send(0);
    repeat (10) @(negedge clk);
    pulse_reset();
    repeat (70) @(negedge clk);
    send(0); wait_idle();

    // reset during the round phase
    send(0);
    k = (sbq[0].size() != 0) ? sbq[0][0].cyc - cyc - 4 : 0;
    repeat (k) @(negedge clk);
    pulse_reset();
    repeat (20) @(negedge clk);
    send(0); wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    n_vec++;
    n_bad++;
    $display("FAIL global_timeout: got no completion by 200000, required completion");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
